// File: rtl/sevenseg_scan_n_if.sv
// Display-side bundle for the multiplexed seven-segment scanner.
// Display logic drives digit, mask and brightness values; the scanner drives the pins.
interface sevenseg_scan_n_if #(
  parameter int NDIG     = 8,
  parameter int BRIGHT_W = 3
);
  logic [NDIG-1:0][3:0]   digits;
  logic [NDIG-1:0]        blank;
  logic [NDIG-1:0]        dpmask;
  logic [BRIGHT_W-1:0]    bright;
  logic [NDIG-1:0]        anode_l;
  logic [6:0]             segs_l;
  logic                   dp_l;
  logic                   frame_tick;

  modport master (
    output digits, blank, dpmask, bright,
    input  anode_l, segs_l, dp_l, frame_tick
  );

  modport slave (
    input  digits, blank, dpmask, bright,
    output anode_l, segs_l, dp_l, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan_n.sv
// Multiplexed NDIG-digit seven-segment scanner: prescaled slots, one-clock dead time, PWM dimming.
// Optional leading-zero suppression when SEVENSEG_LZ_BLANK_EN is defined.
module sevenseg_scan_lane #(
  parameter int IW   = 3,
  parameter int LANE = 0
) (
  input  logic [IW-1:0] idx,
  input  logic [3:0]    digit,
  input  logic          blank,
  input  logic          dpmask,
  output logic          sel,
  output logic [3:0]    digit_sel,
  output logic          dark_sel,
  output logic          dp_sel
);
  // Each lane contributes only while selected, so the top can OR-reduce instead of muxing.
  assign sel       = (idx == IW'(LANE));
  assign digit_sel = sel ? digit : 4'h0;
  assign dark_sel  = sel & blank;
  assign dp_sel    = sel & dpmask;
endmodule

module sevenseg_scan_n #(
  parameter int NDIG     = 8,
  parameter int PRESCALE = 1024,
  parameter int BRIGHT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  sevenseg_scan_n_if.slave   bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [PW-1:0]        pre;
  logic [IW-1:0]        idx;
  logic [BRIGHT_W-1:0]  pwm;
  logic [NDIG-1:0]      blank_eff;
  logic [NDIG-1:0]      sel, dark_sel, dp_sel;
  logic [NDIG-1:0][3:0] digit_sel;
  logic [3:0]           cur_digit;
  logic                 cur_dark, cur_dp, pwm_on, en;

  function automatic logic [6:0] hexdec(input logic [3:0] d);
    case (d)
      4'h0: hexdec = 7'h40;  4'h1: hexdec = 7'h79;
      4'h2: hexdec = 7'h24;  4'h3: hexdec = 7'h30;
      4'h4: hexdec = 7'h19;  4'h5: hexdec = 7'h12;
      4'h6: hexdec = 7'h02;  4'h7: hexdec = 7'h78;
      4'h8: hexdec = 7'h00;  4'h9: hexdec = 7'h10;
      4'hA: hexdec = 7'h08;  4'hB: hexdec = 7'h03;
      4'hC: hexdec = 7'h46;  4'hD: hexdec = 7'h21;
      4'hE: hexdec = 7'h06;  default: hexdec = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + 1'b1;
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [NDIG-1:0] lz_mask;
  logic            zero_run;

  // Walk down from the most significant digit; digit 0 always stays visible.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run   = zero_run & (bus.digits[i] == 4'h0);
      lz_mask[i] = (i != 0) & zero_run;
    end
  end

  assign blank_eff = bus.blank | lz_mask;
`else
  assign blank_eff = bus.blank;
`endif

  for (genvar i = 0; i < NDIG; i++) begin : g_lane
    sevenseg_scan_lane #(.IW(IW), .LANE(i)) u_lane (
      .idx       (idx),
      .digit     (bus.digits[i]),
      .blank     (blank_eff[i]),
      .dpmask    (bus.dpmask[i]),
      .sel       (sel[i]),
      .digit_sel (digit_sel[i]),
      .dark_sel  (dark_sel[i]),
      .dp_sel    (dp_sel[i])
    );
  end

  always_comb begin
    cur_digit = 4'h0;
    for (int i = 0; i < NDIG; i++) cur_digit = cur_digit | digit_sel[i];
  end

  assign cur_dark = |dark_sel;
  assign cur_dp   = |dp_sel;
  assign pwm_on   = (&bus.bright) || (pwm < bus.bright);
  // pre==0 is the dead slot between digits so the previous anode never ghosts.
  assign en       = !cur_dark && (pre != '0) && pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.anode_l    <= '1;
      bus.segs_l     <= 7'h7F;
      bus.dp_l       <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.anode_l    <= ~({NDIG{en}} & sel);
      bus.segs_l     <= en ? hexdec(cur_digit) : 7'h7F;
      bus.dp_l       <= !(en && cur_dp);
      bus.frame_tick <= (pre == PRE_LAST) && (idx == IDX_LAST);
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Scoreboard bench: two scanners (8 digits / prescale 4, and 5 digits / prescale 2)
// checked every clock against a time-based model of the scan.
module tb_sevenseg_scan_n;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } out_t;

  logic        clk, rst;
  logic [31:0] digits;
  logic [7:0]  blank, dpmask;
  logic [2:0]  bright;
  int          cyc;
  int          n_run, n_fail;
  bit          chk_b;
  logic [6:0]  hex_tbl [16];
  out_t        exp_q[$];
  out_t        exp_b_q[$];

  sevenseg_scan_n_if #(.NDIG(8), .BRIGHT_W(3)) bus_a ();
  sevenseg_scan_n_if #(.NDIG(5), .BRIGHT_W(3)) bus_b ();

  assign bus_a.digits = digits;
  assign bus_a.blank  = blank;
  assign bus_a.dpmask = dpmask;
  assign bus_a.bright = bright;
  assign bus_b.digits = digits[19:0];
  assign bus_b.blank  = blank[4:0];
  assign bus_b.dpmask = dpmask[4:0];
  assign bus_b.bright = bright;

  sevenseg_scan_n #(.NDIG(8), .PRESCALE(4), .BRIGHT_W(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  sevenseg_scan_n #(.NDIG(5), .PRESCALE(2), .BRIGHT_W(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench time base: clocks since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected pins after the edge that sees clock count c, derived from c alone.
  function automatic out_t model(int c, int n, int p, logic [31:0] dg, logic [7:0] bl,
                                 logic [7:0] dm, logic [2:0] br);
    out_t m;
    int   pre, idx, pwm;
    logic [7:0] beff;
    logic zero, en;
    pre  = c % p;
    idx  = (c / p) % n;
    pwm  = c % 8;
    beff = bl;
    zero = 1'b1;
`ifdef SEVENSEG_LZ_BLANK_EN
    for (int i = n - 1; i >= 1; i--) begin
      zero = zero && (dg[4*i +: 4] == 4'h0);
      if (zero) beff[i] = 1'b1;
    end
`endif
    en    = !beff[idx] && (pre != 0) && (br == 3'd7 || pwm < int'(br));
    m.an  = 8'hFF;
    if (en) m.an[idx] = 1'b0;
    m.seg = en ? hex_tbl[dg[4*idx +: 4]] : 7'h7F;
    m.dp  = !(en && dm[idx]);
    m.ft  = (pre == p - 1) && (idx == n - 1);
    return m;
  endfunction

  task automatic tick();
    exp_q.push_back(model(cyc, 8, 4, digits, blank, dpmask, bright));
    if (chk_b) exp_b_q.push_back(model(cyc, 5, 2, digits, blank & 8'h1F, dpmask & 8'h1F, bright));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t e, got;
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if (bus_a.anode_l !== 8'hFF || bus_a.segs_l !== 7'h7F || bus_a.dp_l !== 1'b1 || bus_a.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got an=%h seg=%h dp=%b ft=%b, need an=ff seg=7f dp=1 ft=0",
               bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      e   = exp_q.pop_front();
      got = {bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick};
      n_run++;
      if (got !== e || bus_a.anode_l !== ((k == 0) ? 8'hFF : 8'hFE)) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %h, need %h", k, got, e);
      end
    end
  endtask

  task automatic test_scan();
    out_t e, got;
    int lit, last_ft, gap_ok;
    digits = 32'h76543210; blank = 8'h00; dpmask = 8'h00; bright = 3'd7;
    tick();
    void'(exp_q.pop_front());
    lit = 0; last_ft = -1; gap_ok = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      e   = exp_q.pop_front();
      got = {bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scan cyc=%0d: got %h, need %h", cyc, got, e);
      end
      if (bus_a.anode_l !== 8'hFF) lit++;
      if (bus_a.frame_tick === 1'b1) begin
        if (last_ft >= 0 && k - last_ft == 32) gap_ok = 1;
        last_ft = k;
      end
    end
    n_run++;
    if (lit != 48) begin
      n_fail++;
      $display("FAIL scan_duty: got %0d lit clocks, need 48", lit);
    end
    n_run++;
    if (gap_ok != 1) begin
      n_fail++;
      $display("FAIL scan_frame_tick_period: got gap_ok=%0d, need 1", gap_ok);
    end
  endtask

  task automatic test_blank_dp();
    out_t e, got;
    logic [7:0] lit_mask, dp_mask;
    blank = 8'h04; dpmask = 8'h06;
    tick();
    void'(exp_q.pop_front());
    lit_mask = 8'h00; dp_mask = 8'h00;
    for (int k = 0; k < 32; k++) begin
      tick();
      e   = exp_q.pop_front();
      got = {bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick};
      n_run++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL blank_dp cyc=%0d: got %h, need %h", cyc, got, e);
      end
      lit_mask = lit_mask | ~bus_a.anode_l;
      if (bus_a.dp_l === 1'b0) dp_mask = dp_mask | ~bus_a.anode_l;
    end
    n_run++;
    if (lit_mask !== 8'hFB || dp_mask !== 8'h02) begin
      n_fail++;
      $display("FAIL blank_dp_masks: got lit=%h dp=%h, need lit=fb dp=02", lit_mask, dp_mask);
    end
    blank = 8'h00; dpmask = 8'h00;
  endtask

  task automatic test_brightness();
    out_t e, got;
    int lit;
    for (int b = 0; b < 2; b++) begin
      bright = (b == 0) ? 3'd2 : 3'd0;
      tick();
      void'(exp_q.pop_front());
      lit = 0;
      for (int k = 0; k < 32; k++) begin
        tick();
        e   = exp_q.pop_front();
        got = {bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick};
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL bright%0d cyc=%0d: got %h, need %h", bright, cyc, got, e);
        end
        if (bus_a.anode_l !== 8'hFF) lit++;
      end
      // bright=2 with prescale 4: pwm phases 0,1 lit, phase 0 falls on every dead slot.
      n_run++;
      if (lit != ((b == 0) ? 4 : 0)) begin
        n_fail++;
        $display("FAIL bright%0d_duty: got %0d lit clocks, need %0d", bright, lit, (b == 0) ? 4 : 0);
      end
    end
    bright = 3'd7;
  endtask

  task automatic test_lz();
    out_t e, got;
    logic [7:0] lit_mask, need;
    for (int s = 0; s < 2; s++) begin
      digits = (s == 0) ? 32'h00000305 : 32'h00000000;
`ifdef SEVENSEG_LZ_BLANK_EN
      need = (s == 0) ? 8'h07 : 8'h01;
`else
      need = 8'hFF;
`endif
      tick();
      void'(exp_q.pop_front());
      lit_mask = 8'h00;
      for (int k = 0; k < 32; k++) begin
        tick();
        e   = exp_q.pop_front();
        got = {bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick};
        n_run++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL lz%0d cyc=%0d: got %h, need %h", s, cyc, got, e);
        end
        lit_mask = lit_mask | ~bus_a.anode_l;
      end
      n_run++;
      if (lit_mask !== need) begin
        n_fail++;
        $display("FAIL lz%0d_lit_mask: got %h, need %h", s, lit_mask, need);
      end
    end
    digits = 32'h76543210;
  endtask

  task automatic test_nonpow2();
    out_t e, got;
    int last_ft, gap_bad, gaps;
    chk_b = 1'b1;
    digits = 32'hFEDCBA98;
    tick();
    void'(exp_q.pop_front());
    void'(exp_b_q.pop_front());
    last_ft = -1; gap_bad = 0; gaps = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      void'(exp_q.pop_front());
      e   = exp_b_q.pop_front();
      got = {3'b111, bus_b.anode_l, bus_b.segs_l, bus_b.dp_l, bus_b.frame_tick};
      n_run++;
      if (got !== e || $countones(~bus_b.anode_l) > 1) begin
        n_fail++;
        $display("FAIL nonpow2 cyc=%0d: got %h, need %h", cyc, got, e);
      end
      if (bus_b.frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          gaps++;
          if (k - last_ft != 10) gap_bad++;
        end
        last_ft = k;
      end
    end
    n_run++;
    if (gaps != 3 || gap_bad != 0) begin
      n_fail++;
      $display("FAIL nonpow2_frame_period: got gaps=%0d bad=%0d, need gaps=3 bad=0", gaps, gap_bad);
    end
    chk_b = 1'b0;
    digits = 32'h76543210;
  endtask

  task automatic test_reset_mid();
    out_t e, got;
    for (int k = 0; k < 13; k++) begin
      tick();
      void'(exp_q.pop_front());
    end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if (bus_a.anode_l !== 8'hFF || bus_a.segs_l !== 7'h7F || bus_a.dp_l !== 1'b1 || bus_a.frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got an=%h seg=%h dp=%b ft=%b, need an=ff seg=7f dp=1 ft=0",
               bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_run++;
      if (bus_a.anode_l !== 8'hFF || bus_b.anode_l !== 5'h1F || bus_a.frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_hold[%0d]: got an=%h anb=%h ft=%b, need an=ff anb=1f ft=0",
                 k, bus_a.anode_l, bus_b.anode_l, bus_a.frame_tick);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e   = exp_q.pop_front();
      got = {bus_a.anode_l, bus_a.segs_l, bus_a.dp_l, bus_a.frame_tick};
      n_run++;
      if (got !== e || (k == 1 && bus_a.anode_l !== 8'hFE)) begin
        n_fail++;
        $display("FAIL reset_mid_restart[%0d]: got %h, need %h", k, got, e);
      end
    end
  endtask

  initial begin
    hex_tbl[0]  = 7'h40; hex_tbl[1]  = 7'h79; hex_tbl[2]  = 7'h24; hex_tbl[3]  = 7'h30;
    hex_tbl[4]  = 7'h19; hex_tbl[5]  = 7'h12; hex_tbl[6]  = 7'h02; hex_tbl[7]  = 7'h78;
    hex_tbl[8]  = 7'h00; hex_tbl[9]  = 7'h10; hex_tbl[10] = 7'h08; hex_tbl[11] = 7'h03;
    hex_tbl[12] = 7'h46; hex_tbl[13] = 7'h21; hex_tbl[14] = 7'h06; hex_tbl[15] = 7'h0E;
    n_run = 0; n_fail = 0; chk_b = 1'b0;
    rst = 1'b1;
    digits = 32'h76543210; blank = 8'h00; dpmask = 8'h00; bright = 3'd7;
    test_reset();
    test_scan();
    test_blank_dp();
    test_brightness();
    test_lz();
    test_nonpow2();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "timeout");
  end
endmodule
